// File: rtl/pe_array_pkg.sv
// Shared types for the PE-array ID loader: sequencer states, default geometry
// and the layout of one ID table entry.
package pe_array_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ_Y  = 3'd1,
        READ_X  = 3'd2,
        DRAIN   = 3'd3,
        LOAD_LN = 3'd4,
        APPLY   = 3'd5
    } id_ld_state_e;

    localparam int DEF_ROW      = 6;
    localparam int DEF_COL      = 8;
    localparam int DEF_XID_BITS = 5;
    localparam int DEF_YID_BITS = 3;

    localparam int N_Y = DEF_ROW;
    localparam int N_X = DEF_ROW * DEF_COL;

    typedef struct packed {
        logic [DEF_XID_BITS-1:0] ifmap;
        logic [DEF_XID_BITS-1:0] filter;
        logic [DEF_XID_BITS-1:0] ipsum;
        logic [DEF_XID_BITS-1:0] opsum;
    } id_entry_t;

endpackage

// File: rtl/pe_array_id_loader.sv
// Configuration sequencer: ID table -> GIN/GON scan chains, then LN config, then PE config/enables.
// Optional PE_ID_LOADER_LN_ONLY_EN adds an ln_only input that skips the table scan.
module pe_array_id_loader
    import pe_array_pkg::*;
#(
    parameter int NUMS_PE_ROW = DEF_ROW,
    parameter int NUMS_PE_COL = DEF_COL,
    parameter int XID_BITS    = DEF_XID_BITS,
    parameter int YID_BITS    = DEF_YID_BITS,
    parameter int CONFIG_SIZE = 10,
    parameter int TBL_AW      = 6
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
`ifdef PE_ID_LOADER_LN_ONLY_EN
    input  logic                               ln_only,
`endif
    input  logic [NUMS_PE_ROW-2:0]             ln_cfg,
    input  logic [CONFIG_SIZE-1:0]             pe_cfg,
    input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0] pe_en_mask,
    output logic                               busy,
    output logic                               done,
    output logic                               tbl_rd,
    output logic [TBL_AW-1:0]                  tbl_addr,
    input  logic [4*XID_BITS-1:0]              tbl_rdata,
    output logic                               set_XID,
    output logic [XID_BITS-1:0]                ifmap_XID_scan_in,
    output logic [XID_BITS-1:0]                filter_XID_scan_in,
    output logic [XID_BITS-1:0]                ipsum_XID_scan_in,
    output logic [XID_BITS-1:0]                opsum_XID_scan_in,
    output logic                               set_YID,
    output logic [YID_BITS-1:0]                ifmap_YID_scan_in,
    output logic [YID_BITS-1:0]                filter_YID_scan_in,
    output logic [YID_BITS-1:0]                ipsum_YID_scan_in,
    output logic [YID_BITS-1:0]                opsum_YID_scan_in,
    output logic                               set_LN,
    output logic [NUMS_PE_ROW-2:0]             LN_config_in,
    output logic [CONFIG_SIZE-1:0]             PE_config,
    output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0] PE_en
);

    localparam int NY  = NUMS_PE_ROW;
    localparam int NX  = NUMS_PE_ROW * NUMS_PE_COL;
    localparam int NPE = NUMS_PE_ROW * NUMS_PE_COL;

    id_ld_state_e             state, state_nxt;
    logic [TBL_AW-1:0]        cnt;
    logic                     pend_vld, pend_x;
    logic                     accept, skip_scan;
    logic [NUMS_PE_ROW-2:0]   ln_q;
    logic [CONFIG_SIZE-1:0]   cfg_q;
    logic [NPE-1:0]           mask_q;

`ifdef PE_ID_LOADER_LN_ONLY_EN
    assign skip_scan = ln_only;
`else
    assign skip_scan = 1'b0;
`endif

    assign accept = (state == IDLE) && start;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        tbl_rd       = 1'b0;
        tbl_addr     = '0;
        set_LN       = 1'b0;
        LN_config_in = '0;
        done         = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = skip_scan ? LOAD_LN : READ_Y;
            READ_Y: begin
                tbl_rd   = 1'b1;
                tbl_addr = cnt;
                if (cnt == '0) state_nxt = READ_X;
            end
            READ_X: begin
                tbl_rd   = 1'b1;
                tbl_addr = cnt + TBL_AW'(NY);
                if (cnt == '0) state_nxt = DRAIN;
            end
            DRAIN:   state_nxt = LOAD_LN;
            LOAD_LN: begin
                set_LN       = 1'b1;
                LN_config_in = ln_q;
                state_nxt    = APPLY;
            end
            APPLY: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Index counter runs highest-first and parks at 0; reloaded for the X pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            cnt <= TBL_AW'(NY - 1);
        end else if (state == READ_Y) begin
            cnt <= (cnt == '0) ? TBL_AW'(NX - 1) : cnt - 1'b1;
        end else if (state == READ_X && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld <= 1'b0;
            pend_x   <= 1'b0;
        end else begin
            pend_vld <= tbl_rd;
            pend_x   <= (state == READ_X);
        end
    end

    assign set_YID = pend_vld & ~pend_x;
    assign set_XID = pend_vld &  pend_x;

    assign ifmap_XID_scan_in  = set_XID ? tbl_rdata[3*XID_BITS +: XID_BITS] : '0;
    assign filter_XID_scan_in = set_XID ? tbl_rdata[2*XID_BITS +: XID_BITS] : '0;
    assign ipsum_XID_scan_in  = set_XID ? tbl_rdata[1*XID_BITS +: XID_BITS] : '0;
    assign opsum_XID_scan_in  = set_XID ? tbl_rdata[0*XID_BITS +: XID_BITS] : '0;

    assign ifmap_YID_scan_in  = set_YID ? tbl_rdata[3*XID_BITS +: YID_BITS] : '0;
    assign filter_YID_scan_in = set_YID ? tbl_rdata[2*XID_BITS +: YID_BITS] : '0;
    assign ipsum_YID_scan_in  = set_YID ? tbl_rdata[1*XID_BITS +: YID_BITS] : '0;
    assign opsum_YID_scan_in  = set_YID ? tbl_rdata[0*XID_BITS +: YID_BITS] : '0;

    always_ff @(posedge clk) begin
        if (accept) begin
            ln_q   <= ln_cfg;
            cfg_q  <= pe_cfg;
            mask_q <= pe_en_mask;
        end
    end

    // The array stays idle from acceptance until APPLY publishes the new enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            PE_config <= '0;
            PE_en     <= '0;
        end else if (accept) begin
            PE_en <= '0;
        end else if (state == APPLY) begin
            PE_config <= cfg_q;
            PE_en     <= mask_q;
        end
    end

endmodule
